gain_apply: RTL and testbench
=============================

Name: gain_apply

Overview:
- Downstream consumer of the switch-selected gain word (8-bit unsigned Q1.7; 0x80 = 1.0, 0xE0 = 1.75).
- Applies that gain to a stream of signed audio samples.
- Ramps the applied gain toward the requested gain to avoid zipper noise; rounds and saturates the product.
- Sits between the sample source and the output/codec path, with valid/ready handshakes on both sides.

Parameters:
DATA_W, 16, sample width (signed two's complement)
GAIN_W, 8, gain word width (unsigned)
GAIN_FRAC, 7, fractional bits of gain (Q1.7)
RAMP_STEP, 4, gain LSBs moved toward target per accepted sample
CLIP_CNT_W, 16, width of saturating clip counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
gain_tgt  in  GAIN_W  requested gain (from switch gain decode), sampled every cycle
in_data  in  DATA_W  input sample, signed
in_valid  in  1  input sample valid
in_ready  out  1  block can accept input this cycle
out_data  out  DATA_W  scaled, rounded, saturated sample
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_clip  out  1  current out_data was saturated (qualified by out_valid)
ramping  out  1  gain_cur != gain_tgt
clip_cnt  out  CLIP_CNT_W  number of saturated samples delivered, saturating
clr_clip  in  1  synchronous clear of clip_cnt

Behaviour:
- Reset (rst=1 at a clk edge): gain_cur=0, both pipe stage valids=0, out_data=0, out_valid=0, out_clip=0, clip_cnt=0. The block fades in from mute after reset. Reset mid-ramp or mid-stall drops in-flight samples; no partial outputs.
- Handshake: advance = !out_valid | out_ready; in_ready = advance.
- Input accepted when in_valid & in_ready. Output transferred when out_valid & out_ready.
- out_data, out_valid and out_clip hold stable while out_valid & !out_ready.
- Pipeline: 2 register stages moving in lockstep on advance. Latency 2 cycles from acceptance to out_valid when out_ready stays high. Throughput 1 sample/cycle. Bubbles are not collapsed.
- Stage 1 on acceptance:
  - product = in_data (signed DATA_W) × {0, gain_cur} (signed GAIN_W+1), giving a DATA_W+GAIN_W+1-bit signed result.
  - Uses gain_cur as it was before this cycle's ramp update.
- Stage 2:
  - r = (product + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC (round half toward +inf).
  - If r > 2^(DATA_W-1)-1: out = max positive, out_clip=1.
  - If r < -2^(DATA_W-1): out = min negative, out_clip=1.
  - Otherwise out = r, out_clip=0.
- Gain ramp, updated only on an accepted input sample:
  - gain_cur < gain_tgt: gain_cur = min(gain_cur+RAMP_STEP, gain_tgt).
  - gain_cur > gain_tgt: gain_cur = max(gain_cur-RAMP_STEP, gain_tgt).
  - Equal: hold.
  - The step never overshoots and never wraps, including for targets 0x00 and 0xFF. A gain_tgt change mid-ramp redirects from the present gain_cur.
- ramping is combinational: gain_cur != gain_tgt.
- clip_cnt:
  - Increments on each output transfer with out_clip=1.
  - Saturates at all-ones.
  - clr_clip has priority over increment in the same cycle.
  - rst clears it.
- No state machine beyond the ramp comparator. The ramp has three implicit states: UP, DOWN, HOLD, chosen by comparing gain_cur with gain_tgt.

Decomposition:
- Shared package (audio_pkg):
  - DATA_W, GAIN_W, GAIN_FRAC.
  - Gain constants GAIN_ZERO=0x00, GAIN_UNITY=0x80, GAIN_MAX=0xE0.
  - Typedefs sample_t (signed DATA_W) and gain_t (unsigned GAIN_W).
- One sub-module: gain_ramp (gain_cur register + step/clamp logic, inputs gain_tgt and step_en). Multiply, round and saturate stay inline.

Test Plan:
- rst then gain_tgt=0x80, RAMP_STEP=4; feed 32 samples -> gain_cur reaches 0x80 on the 32nd accept; ramping deasserts; sample 33 of value 1000 appears as 1000 two cycles later.
- Hold gain_cur=0xE0, in_data=30000 -> out_data=32767, out_clip=1, clip_cnt=1; in_data=-30000 -> out_data=-32768, clip_cnt=2.
- Hold gain_cur=0x20 (0.25), in_data=-3 -> out_data=-1 (-96+64=-32, >>>7); in_data=2 -> out_data=1 (64+64=128, >>>7 = 1).
- Streaming with out_ready low for 5 cycles mid-stream -> in_ready low; out_data stable; no sample lost or duplicated; order preserved against the reference model.
- Mid-ramp (gain_cur=0x40, target 0xE0), assert rst 1 cycle -> out_valid=0 next cycle, gain_cur=0, clip_cnt=0; ramp restarts from 0.
- clr_clip asserted in the same cycle as a clipped output transfer -> clip_cnt=0; with clip_cnt at 0xFFFF, a further clip -> stays 0xFFFF.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, gain constants and types for the audio gain path
package audio_pkg;
    localparam int DATA_W    = 16;
    localparam int GAIN_W    = 8;
    localparam int GAIN_FRAC = 7;
    localparam logic [GAIN_W-1:0] GAIN_ZERO  = 8'h00;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'h80;
    localparam logic [GAIN_W-1:0] GAIN_MAX   = 8'hE0;
    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [GAIN_W-1:0] gain_t;
    typedef enum logic [1:0] {HOLD, UP, DOWN} ramp_dir_t;
endpackage

// File: rtl/gain_ramp.sv
// gain_ramp: slews the applied gain toward the target by a fixed step per accepted sample, never overshooting
module gain_ramp
    import audio_pkg::*;
#(
    parameter int GAIN_W    = audio_pkg::GAIN_W,
    parameter int RAMP_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GAIN_W-1:0] gain_tgt,
    input  logic              step_en,
    output logic [GAIN_W-1:0] gain_cur
);
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);
    ramp_dir_t         dir;
    logic [GAIN_W-1:0] gain_nxt;
    // pick direction and clamp the step to the remaining distance so the gain never wraps
    always_comb begin
        dir      = gain_cur < gain_tgt ? UP : gain_cur > gain_tgt ? DOWN : HOLD;
        gain_nxt = dir == UP   ? (gain_tgt - gain_cur <= STEP ? gain_tgt : gain_cur + STEP) :
                   dir == DOWN ? (gain_cur - gain_tgt <= STEP ? gain_tgt : gain_cur - STEP) :
                   gain_cur;
    end
    // gain register: starts muted and moves only when a sample is accepted
    always_ff @(posedge clk) begin
        if (rst) gain_cur <= GAIN_W'(GAIN_ZERO);
        else if (step_en) gain_cur <= gain_nxt;
    end
endmodule

// File: rtl/gain_apply.sv
// gain_apply: ramped Q1.7 gain applied to a signed sample stream with rounding, saturation and clip counting
module gain_apply #(
    parameter int DATA_W     = audio_pkg::DATA_W,
    parameter int GAIN_W     = audio_pkg::GAIN_W,
    parameter int GAIN_FRAC  = audio_pkg::GAIN_FRAC,
    parameter int RAMP_STEP  = 4,
    parameter int CLIP_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [GAIN_W-1:0]        gain_tgt,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_clip,
    output logic                     ramping,
    output logic [CLIP_CNT_W-1:0]    clip_cnt,
    input  logic                     clr_clip
);
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int R_W    = PROD_W - GAIN_FRAC + 1;
    localparam logic signed [R_W-1:0] MAX_P = {{(R_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [R_W-1:0] MIN_N = ~MAX_P;
    localparam logic signed [PROD_W:0] HALF = (PROD_W+1)'(1) << (GAIN_FRAC-1);
    logic                     advance;
    logic [GAIN_W-1:0]        gain_cur;
    logic                     p1_valid;
    logic signed [PROD_W-1:0] p1_prod;
    logic signed [PROD_W:0]   rounded;
    logic signed [R_W-1:0]    r;
    logic                     hi;
    logic                     lo;
    logic [DATA_W-1:0]        sat_data;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign ramping  = gain_cur != gain_tgt;
    gain_ramp #(.GAIN_W(GAIN_W), .RAMP_STEP(RAMP_STEP)) u_ramp (
        .clk      (clk),
        .rst      (rst),
        .gain_tgt (gain_tgt),
        .step_en  (in_valid && advance),
        .gain_cur (gain_cur)
    );
    // round half toward +inf, then clamp to the sample range
    always_comb begin
        rounded  = {p1_prod[PROD_W-1], p1_prod} + HALF;
        r        = $signed(rounded[PROD_W:GAIN_FRAC]);
        hi       = r > MAX_P;
        lo       = r < MIN_N;
        sat_data = hi ? {1'b0, {(DATA_W-1){1'b1}}} : lo ? {1'b1, {(DATA_W-1){1'b0}}} : r[DATA_W-1:0];
    end
    // two-stage pipe advancing in lockstep; output holds while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid  <= 1'b0;
            p1_prod   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_clip  <= 1'b0;
        end else if (advance) begin
            p1_valid  <= in_valid;
            p1_prod   <= $signed(in_data) * $signed({1'b0, gain_cur});
            out_valid <= p1_valid;
            out_data  <= sat_data;
            out_clip  <= hi || lo;
        end
    end
    // saturating count of clipped samples actually handed downstream; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || clr_clip) clip_cnt <= '0;
        else if (out_valid && out_ready && out_clip && !(&clip_cnt)) clip_cnt <= clip_cnt + 1'b1;
    end
endmodule

// File: tb/tb_gain_apply.sv
// tb_gain_apply: directed stimulus with a scoreboard and ramp/clip model for gain_apply
module tb_gain_apply;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         gain_tgt = 8'h80;
    logic signed [15:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [15:0]        out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               out_clip;
    logic               ramping;
    logic [15:0]        clip_cnt;
    logic               clr_clip = 1'b0;
    int tests = 0;
    int fails = 0;
    int g = 0;
    int cnt = 0;
    logic [15:0] qd[$];
    logic        qc[$];

    gain_apply dut (
        .clk(clk), .rst(rst), .gain_tgt(gain_tgt), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_clip(out_clip), .ramping(ramping), .clip_cnt(clip_cnt), .clr_clip(clr_clip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input int x, input int gn);
        longint p = longint'(x) * gn + 64;
        longint r = p >= 0 ? p / 128 : -((-p + 127) / 128);
        if (r > 32767) return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(r)};
    endfunction

    function automatic int ramp(input int cur, input int tgt);
        if (cur < tgt) return (cur + 4 > tgt) ? tgt : cur + 4;
        if (cur > tgt) return (cur - 4 < tgt) ? tgt : cur - 4;
        return cur;
    endfunction

    task automatic tick();
        bit acc;
        bit xfer;
        bit eclip;
        logic [16:0] e;
        #1;
        acc = !rst && in_valid && in_ready;
        xfer = !rst && out_valid && out_ready;
        eclip = 1'b0;
        if (xfer) begin
            if (qd.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                chk("out_data", out_data, qd[0]);
                chk("out_clip", out_clip, qc[0]);
                eclip = qc[0];
                void'(qd.pop_front());
                void'(qc.pop_front());
            end
        end
        if (rst || clr_clip) cnt = 0;
        else if (xfer && eclip && cnt != 65535) cnt++;
        if (acc) begin
            e = model(int'(in_data), g);
            qd.push_back(e[15:0]);
            qc.push_back(e[16]);
            g = ramp(g, int'(gain_tgt));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            qd.delete();
            qc.delete();
            g = 0;
        end
        chk("ramping", ramping, g != int'(gain_tgt));
        chk("clip_cnt", clip_cnt, cnt);
    endtask

    task automatic one_shot(input logic signed [15:0] d);
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic [15:0] hold;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_clip", out_clip, 0);
        chk("rst_clip_cnt", clip_cnt, 0);
        chk("rst_ramping", ramping, 1);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 16'sd1000;
        for (int i = 0; i < 31; i++) tick();
        chk("ramp_31_still", ramping, 1);
        tick();
        chk("ramp_32_done", ramping, 0);
        one_shot(16'sd1000);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 16'd1000);
        gain_tgt = 8'hE0;
        in_valid = 1'b1;
        in_data = 0;
        for (int i = 0; i < 24; i++) tick();
        chk("ramp_e0", ramping, 0);
        one_shot(16'sd30000);
        chk("clip_pos_data", out_data, 16'h7FFF);
        chk("clip_pos_flag", out_clip, 1);
        tick();
        chk("clip_cnt_1", clip_cnt, 1);
        one_shot(-16'sd30000);
        chk("clip_neg_data", out_data, 16'h8000);
        chk("clip_neg_flag", out_clip, 1);
        tick();
        chk("clip_cnt_2", clip_cnt, 2);
        one_shot(16'sd30000);
        clr_clip = 1'b1;
        tick();
        clr_clip = 1'b0;
        chk("clr_priority", clip_cnt, 0);
        in_valid = 1'b1;
        in_data = 16'sd30000;
        for (int i = 0; i < 65540; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("clip_sat", clip_cnt, 16'hFFFF);
        gain_tgt = 8'h20;
        in_valid = 1'b1;
        in_data = 0;
        for (int i = 0; i < 48; i++) tick();
        chk("ramp_20", ramping, 0);
        one_shot(-16'sd3);
        chk("round_neg3", out_data, 16'hFFFF);
        one_shot(16'sd2);
        chk("round_pos2", out_data, 16'd1);
        gain_tgt = 8'h22;
        in_valid = 1'b1;
        in_data = 0;
        tick();
        chk("no_overshoot_22", ramping, 0);
        gain_tgt = 8'hFF;
        for (int i = 0; i < 55; i++) tick();
        chk("ramp_ff_55", ramping, 1);
        tick();
        chk("ramp_ff", ramping, 0);
        gain_tgt = 8'h00;
        for (int i = 0; i < 63; i++) tick();
        chk("ramp_00_63", ramping, 1);
        tick();
        chk("ramp_00", ramping, 0);
        gain_tgt = 8'h80;
        for (int i = 0; i < 40; i++) begin
            in_data = 16'($urandom);
            if (i >= 15 && i < 20) begin
                out_ready = 1'b0;
                #1;
                chk("stall_in_ready", in_ready, 0);
                hold = out_data;
                tick();
                chk("stall_hold", out_data, hold);
            end else begin
                out_ready = 1'b1;
                tick();
            end
        end
        gain_tgt = 8'h40;
        in_data = 16'sd1000;
        for (int i = 0; i < 16; i++) tick();
        chk("gain_40", dut.u_ramp.gain_cur, 8'h40);
        gain_tgt = 8'hE0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_clip_cnt", clip_cnt, 0);
        chk("mid_rst_gain", dut.u_ramp.gain_cur, 0);
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        chk("restart_step", out_data, 16'd31);
        for (int i = 0; i < 20 && qd.size() != 0; i++) tick();
        chk("drain", qd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
